rtc_bus_seq: RTL and testbench
==============================

// Module: rtc_bus_seq
// PURPOSE
//  Sequencer for the RTC multiplexed address/data bus. Arbitrates init, configuration and time-read
//  requests, then steps the access index consumed by the direc_data address/data mux.
//  Generates the cs_n/rd_n/wr_n/ad_n strobes plus the address/data phase select (cont_es).
//  Returns read bytes with their index. Sits between the top-level control FSM and the RTC pins.
// PARAMETERS
//  T_ADDR       4          cycles of address phase per access
//  T_DATA       4          cycles of data phase (rd_n or wr_n low)
//  T_GAP        2          idle cycles between accesses (all strobes high)
//  AUTO_PERIOD  1000000    cycles between automatic read requests (RTC_AUTO_READ_EN only)
// PORTS
//  clk        in   1  system clock
//  clr        in   1  asynchronous active-high reset
//  req_ini    in   1  request init sequence (pulse or level; latched)
//  req_conf   in   1  request config-write sequence (latched)
//  req_lect   in   1  request time-read sequence (latched)
//  din        in   8  RTC bus input byte (sampled in read data phase)
//  estado     out  5  mux state code: 5'b01100 register access, 5'b10011 command access
//  cont       out  4  access index to mux
//  ini        out  1  high for whole init sequence
//  lect       out  1  high for whole read sequence
//  cont_es    out  1  0 = mux outputs address, 1 = mux outputs data
//  ad_oe      out  1  bus drive enable (0 during read data phase and idle)
//  cs_n, rd_n, wr_n, ad_n  out  1 each  RTC bus strobes, active low
//  rd_data    out  8  captured read byte;  rd_idx out 4 index of rd_data;  rd_valid out 1 one-cycle strobe
//  busy       out  1  sequence in progress;  done out 1 one-cycle pulse at sequence end
// BEHAVIOUR
//  - Reset (async, clr=1): state IDLE, pending flags 0, estado=0, cont=0, ini=lect=cont_es=ad_oe=0,
//    strobes all 1, rd_data=0, rd_idx=0, rd_valid=busy=done=0. Reset mid-access aborts cleanly, no done.
//  - Requests latched into pending flags every cycle, incl. while busy; repeats merge. Flag cleared when
//    its sequence starts. Priority at IDLE: ini > conf > lect. No preemption of a running sequence.
//  - IDLE with pending: next edge -> ADDR, busy=1. Per access: ADDR(T_ADDR) cs_n=0 ad_n=0 wr_n=0
//    cont_es=0 ad_oe=1 -> TURN(1) all strobes 1, cont_es=1, ad_oe=write -> DATA(T_DATA) cs_n=0 and
//    wr_n=0 (write, ad_oe=1) or rd_n=0 (read, ad_oe=0) -> GAP(T_GAP) strobes 1, ad_oe=0.
//    Access = T_ADDR+1+T_DATA+T_GAP cycles (11 default).
//  - Read: din sampled on last DATA cycle; next cycle rd_valid=1, rd_data=din, rd_idx=cont.
//  - INIT: ini=1, estado=01100, cont 0..13, all writes (14 accesses).
//  - CONF: estado=01100, cont 1..3, writes (3 accesses).
//  - LECT: lect=1; access 0 is command write with estado=10011; then estado=01100, cont 1..9 reads.
//  - cont/estado/ini/lect stable for whole access; cont increments in the GAP->ADDR transition only.
//  - After last GAP: done=1 for one cycle, busy=0, return to IDLE. The next pending sequence may start
//    the following cycle. Outputs estado/cont hold their last values in IDLE.
//  - Phase counter width = clog2(max(T_ADDR,T_DATA,T_GAP)+1); any T_* >= 1 required.
// CONFIGURATION
//  RTC_AUTO_READ_EN defined: internal counter 0..AUTO_PERIOD-1 wraps and sets the lect pending flag on
//    wrap; counter reset by clr; runs while busy. Undefined: counter absent, reads only via req_lect.
// TESTING
//  1 clr pulse mid-DATA of a write -> next cycle all strobes 1, busy=0, no done, pending cleared.
//  2 req_ini 1-cycle at t0 -> cs_n low from t0+1; 14 accesses; done at t0+155; cont saw 0..13.
//  3 req_lect with din=8'h37 -> one wr_n access at estado=10011, then 9 rd_n accesses.
//    9 rd_valid pulses, rd_idx 1..9, rd_data=8'h37 each.
//  4 req_conf and req_lect same cycle -> conf (3 writes, cont 1..3) first, lect starts cycle after done.
//  5 req_ini during running lect -> lect completes (10 accesses), ini starts next cycle, ini=1 throughout.
//  6 RTC_AUTO_READ_EN, AUTO_PERIOD=200, no requests -> lect sequence begins every 200 cycles.

Source files
------------

// File: rtl/rtc_bus_seq.sv
// rtc_bus_seq: sequencer for the RTC multiplexed address/data bus.
// Arbitrates init / config-write / time-read requests, steps the access index
// for the address/data mux and drives the cs_n/rd_n/wr_n/ad_n strobes.
// Optional build macro: RTC_AUTO_READ_EN adds a free-running timer that queues
// a time-read sequence every AUTO_PERIOD cycles.
//
// state  | meaning
// IDLE   | no access; strobes high, waiting on a pending request
// ADDR   | address phase (T_ADDR cycles), mux outputs address
// TURN   | one-cycle turnaround, strobes high, mux switched to data
// DATA   | data phase (T_DATA cycles), wr_n or rd_n low
// GAP    | idle gap between accesses (T_GAP cycles)
module rtc_bus_seq #(
  parameter int T_ADDR      = 4,
  parameter int T_DATA      = 4,
  parameter int T_GAP       = 2,
  parameter int AUTO_PERIOD = 1000000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       req_ini,
  input  logic       req_conf,
  input  logic       req_lect,
  input  logic [7:0] din,
  output logic [4:0] estado,
  output logic [3:0] cont,
  output logic       ini,
  output logic       lect,
  output logic       cont_es,
  output logic       ad_oe,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       ad_n,
  output logic [7:0] rd_data,
  output logic [3:0] rd_idx,
  output logic       rd_valid,
  output logic       busy,
  output logic       done
);

  localparam int T_MAX_AD = (T_ADDR > T_DATA) ? T_ADDR : T_DATA;
  localparam int T_MAX    = (T_MAX_AD > T_GAP) ? T_MAX_AD : T_GAP;
  localparam int PW       = $clog2(T_MAX + 1);

  localparam logic [4:0] EST_REG = 5'b01100;
  localparam logic [4:0] EST_CMD = 5'b10011;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_TURN, S_DATA, S_GAP} state_t;
  typedef enum logic [1:0] {Q_INIT, Q_CONF, Q_LECT} seq_t;

  state_t        state;
  seq_t          seq;
  logic [PW-1:0] phase;
  logic          pend_ini, pend_conf, pend_lect;
  logic          auto_hit;
  logic          want_ini, want_conf, want_lect;
  logic          start_ini, start_conf, start_lect;
  logic          is_write;
  logic [3:0]    last_cont;

`ifdef RTC_AUTO_READ_EN
  localparam int AW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  logic [AW-1:0] auto_cnt;

  assign auto_hit = (auto_cnt == AW'(AUTO_PERIOD - 1));

  // free-running period timer, keeps counting while a sequence is busy
  always_ff @(posedge clk or posedge clr) begin
    if (clr)           auto_cnt <= '0;
    else if (auto_hit) auto_cnt <= '0;
    else               auto_cnt <= auto_cnt + 1'b1;
  end
`else
  assign auto_hit = 1'b0;
`endif

  // a request arriving in IDLE starts on the very next edge, so the raw
  // request is OR-ed with the pending flag here
  assign want_ini   = pend_ini  | req_ini;
  assign want_conf  = pend_conf | req_conf;
  assign want_lect  = pend_lect | req_lect | auto_hit;
  assign start_ini  = (state == S_IDLE) & want_ini;
  assign start_conf = (state == S_IDLE) & ~want_ini & want_conf;
  assign start_lect = (state == S_IDLE) & ~want_ini & ~want_conf & want_lect;

  // only the command access (index 0) of a read sequence is a write
  assign is_write = (seq != Q_LECT) || (cont == 4'd0);

  // final access index of the running sequence
  always_comb begin
    last_cont = 4'd13;
    case (seq)
      Q_CONF:  last_cont = 4'd3;
      Q_LECT:  last_cont = 4'd9;
      default: last_cont = 4'd13;
    endcase
  end

  // request latches: repeats merge, flag drops when its sequence starts
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pend_ini  <= 1'b0;
      pend_conf <= 1'b0;
      pend_lect <= 1'b0;
    end else begin
      pend_ini  <= want_ini  & ~start_ini;
      pend_conf <= want_conf & ~start_conf;
      pend_lect <= want_lect & ~start_lect;
    end
  end

  // access sequencer with registered bus strobes and status
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= S_IDLE;
      seq      <= Q_INIT;
      phase    <= '0;
      estado   <= 5'd0;
      cont     <= 4'd0;
      ini      <= 1'b0;
      lect     <= 1'b0;
      cont_es  <= 1'b0;
      ad_oe    <= 1'b0;
      cs_n     <= 1'b1;
      rd_n     <= 1'b1;
      wr_n     <= 1'b1;
      ad_n     <= 1'b1;
      rd_data  <= 8'd0;
      rd_idx   <= 4'd0;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_ini || start_conf || start_lect) begin
            state   <= S_ADDR;
            phase   <= PW'(T_ADDR - 1);
            busy    <= 1'b1;
            cs_n    <= 1'b0;
            ad_n    <= 1'b0;
            wr_n    <= 1'b0;
            rd_n    <= 1'b1;
            cont_es <= 1'b0;
            ad_oe   <= 1'b1;
            if (start_ini) begin
              seq    <= Q_INIT;
              ini    <= 1'b1;
              lect   <= 1'b0;
              estado <= EST_REG;
              cont   <= 4'd0;
            end else if (start_conf) begin
              seq    <= Q_CONF;
              ini    <= 1'b0;
              lect   <= 1'b0;
              estado <= EST_REG;
              cont   <= 4'd1;
            end else begin
              seq    <= Q_LECT;
              ini    <= 1'b0;
              lect   <= 1'b1;
              estado <= EST_CMD;
              cont   <= 4'd0;
            end
          end
        end
        S_ADDR: begin
          if (phase == '0) begin
            state   <= S_TURN;
            cs_n    <= 1'b1;
            ad_n    <= 1'b1;
            wr_n    <= 1'b1;
            cont_es <= 1'b1;
            ad_oe   <= is_write;
          end else begin
            phase <= phase - 1'b1;
          end
        end
        S_TURN: begin
          state <= S_DATA;
          phase <= PW'(T_DATA - 1);
          cs_n  <= 1'b0;
          wr_n  <= ~is_write;
          rd_n  <= is_write;
        end
        S_DATA: begin
          if (phase == '0) begin
            state   <= S_GAP;
            phase   <= PW'(T_GAP - 1);
            cs_n    <= 1'b1;
            wr_n    <= 1'b1;
            rd_n    <= 1'b1;
            ad_oe   <= 1'b0;
            cont_es <= 1'b0;
            if (!is_write) begin
              rd_valid <= 1'b1;
              rd_data  <= din;
              rd_idx   <= cont;
            end
          end else begin
            phase <= phase - 1'b1;
          end
        end
        S_GAP: begin
          if (phase != '0) begin
            phase <= phase - 1'b1;
          end else if (cont == last_cont) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            ini   <= 1'b0;
            lect  <= 1'b0;
          end else begin
            state   <= S_ADDR;
            phase   <= PW'(T_ADDR - 1);
            cont    <= cont + 1'b1;
            estado  <= EST_REG;
            cs_n    <= 1'b0;
            ad_n    <= 1'b0;
            wr_n    <= 1'b0;
            ad_oe   <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_bus_seq.sv
// Self-checking bench for rtc_bus_seq: table of whole-sequence vectors plus
// hand-written sequences for reset abort, arbitration and queued requests.
module tb_rtc_bus_seq;

  logic       clk = 1'b0;
  logic       clr;
  logic       req_ini, req_conf, req_lect;
  logic [7:0] din;
  logic [4:0] estado;
  logic [3:0] cont;
  logic       ini, lect, cont_es, ad_oe;
  logic       cs_n, rd_n, wr_n, ad_n;
  logic [7:0] rd_data;
  logic [3:0] rd_idx;
  logic       rd_valid, busy, done;

  rtc_bus_seq #(.AUTO_PERIOD(200)) dut (
    .clk(clk), .clr(clr), .req_ini(req_ini), .req_conf(req_conf), .req_lect(req_lect),
    .din(din), .estado(estado), .cont(cont), .ini(ini), .lect(lect), .cont_es(cont_es),
    .ad_oe(ad_oe), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .ad_n(ad_n), .rd_data(rd_data),
    .rd_idx(rd_idx), .rd_valid(rd_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // statistics gathered by observe()
  int first_cs, first_busy, done_k, acc_cnt, addr_cyc, wr_cyc, rd_cyc;
  int busy_cyc, ini_cyc, lect_cyc, rv_cnt, rv_err, oe_err, cont_err;
  int conts[32];
  int ests[32];
  logic [7:0] exp_din;

  // watch the bus one cycle at a time until done or budget; optionally
  // pulse req_ini for one cycle at sample inj_k
  task automatic observe(input int budget, input int inj_k);
    int prev_cs, prev_cont;
    prev_cs = 1; prev_cont = int'(cont);
    first_cs = -1; first_busy = -1; done_k = 0; acc_cnt = 0; addr_cyc = 0;
    wr_cyc = 0; rd_cyc = 0; busy_cyc = 0; ini_cyc = 0; lect_cyc = 0;
    rv_cnt = 0; rv_err = 0; oe_err = 0; cont_err = 0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (k == 1) begin
        first_cs = int'(cs_n); first_busy = int'(busy);
      end
      if (prev_cs == 1 && !cs_n && !ad_n) begin
        if (acc_cnt < 32) begin
          conts[acc_cnt] = int'(cont); ests[acc_cnt] = int'(estado);
        end
        acc_cnt++;
      end else if (int'(cont) != prev_cont) begin
        cont_err++;
      end
      if (!cs_n && !ad_n) begin
        addr_cyc++;
        if (!ad_oe || cont_es) oe_err++;
      end
      if (!cs_n && ad_n && !wr_n) begin
        wr_cyc++;
        if (!ad_oe || !cont_es) oe_err++;
      end
      if (!cs_n && ad_n && !rd_n) begin
        rd_cyc++;
        if (ad_oe || !cont_es) oe_err++;
      end
      if (busy) busy_cyc++;
      if (ini)  ini_cyc++;
      if (lect) lect_cyc++;
      if (rd_valid) begin
        rv_cnt++;
        if (rd_data != exp_din || int'(rd_idx) != rv_cnt) rv_err++;
      end
      prev_cs = int'(cs_n); prev_cont = int'(cont);
      if (k == 1) begin
        req_ini = 1'b0; req_conf = 1'b0; req_lect = 1'b0;
      end
      if (k == inj_k)     req_ini = 1'b1;
      if (k == inj_k + 1) req_ini = 1'b0;
      if (done) begin
        done_k = k;
        break;
      end
    end
  endtask

  task automatic check_seq(input string tag, input int n, input int nwr, input int nrd,
                           input int c0, input logic [4:0] est0, input logic e_ini,
                           input logic e_lect);
    int seq_err, est_err;
    seq_err = 0; est_err = 0;
    for (int i = 0; i < acc_cnt && i < 32; i++) begin
      if (conts[i] != c0 + i) seq_err++;
      if (i > 0 && ests[i] != 5'b01100) est_err++;
    end
    check({tag, "_start_cs"}, first_cs, 0);
    check({tag, "_start_busy"}, first_busy, 1);
    check({tag, "_done_cycle"}, done_k, 11 * n + 1);
    check({tag, "_accesses"}, acc_cnt, n);
    check({tag, "_first_cont"}, conts[0], c0);
    check({tag, "_cont_steps"}, seq_err, 0);
    check({tag, "_cont_stable"}, cont_err, 0);
    check({tag, "_first_estado"}, ests[0], int'(est0));
    check({tag, "_later_estado"}, est_err, 0);
    check({tag, "_addr_cycles"}, addr_cyc, 4 * n);
    check({tag, "_wr_cycles"}, wr_cyc, 4 * nwr);
    check({tag, "_rd_cycles"}, rd_cyc, 4 * nrd);
    check({tag, "_oe_phase"}, oe_err, 0);
    check({tag, "_busy_cycles"}, busy_cyc, 11 * n);
    check({tag, "_ini_cycles"}, ini_cyc, e_ini ? 11 * n : 0);
    check({tag, "_lect_cycles"}, lect_cyc, e_lect ? 11 * n : 0);
    check({tag, "_rd_valid"}, rv_cnt, nrd);
    check({tag, "_rd_payload"}, rv_err, 0);
  endtask

  typedef struct {
    logic       r_ini, r_conf, r_lect;
    logic [7:0] d;
    int         n, nwr, nrd, c0;
    logic [4:0] est0;
    logic       e_ini, e_lect;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int found, late_busy, late_done, k1, k2;
    vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h00, 14, 14, 0, 0, 5'b01100, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 8'h00, 3, 3, 0, 1, 5'b01100, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 8'h37, 10, 1, 9, 0, 5'b10011, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 8'hA5, 10, 1, 9, 0, 5'b10011, 1'b0, 1'b1};

    clr = 1'b1; req_ini = 1'b0; req_conf = 1'b0; req_lect = 1'b0; din = 8'h00;
    exp_din = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_estado", int'(estado), 0);
    check("rst_cont", int'(cont), 0);
    check("rst_flags", int'({ini, lect, cont_es, ad_oe, rd_valid, busy, done}), 0);
    check("rst_strobes", int'({cs_n, rd_n, wr_n, ad_n}), 15);
    check("rst_rd", int'({rd_data, rd_idx}), 0);
    clr = 1'b0;
    @(negedge clk);

`ifdef RTC_AUTO_READ_EN
    k1 = 0; k2 = 0;
    for (int k = 1; k <= 500; k++) begin
      @(negedge clk);
      if (lect && k1 == 0) k1 = k;
      else if (lect && k1 != 0 && k2 == 0 && !busy) k2 = -1;
      if (k1 != 0 && k > k1 + 150 && lect && k2 == 0) begin
        k2 = k;
        break;
      end
    end
    check("auto_first_lect", int'(k1 != 0 && k1 <= 201), 1);
    check("auto_period", k2 - k1, 200);
`else
    // table of complete sequences
    for (int v = 0; v < 4; v++) begin
      @(negedge clk);
      din = vecs[v].d; exp_din = vecs[v].d;
      req_ini = vecs[v].r_ini; req_conf = vecs[v].r_conf; req_lect = vecs[v].r_lect;
      observe(400, 0);
      check_seq($sformatf("vec%0d", v), vecs[v].n, vecs[v].nwr, vecs[v].nrd, vecs[v].c0,
                vecs[v].est0, vecs[v].e_ini, vecs[v].e_lect);
      @(negedge clk);
      check($sformatf("vec%0d_idle_busy", v), int'(busy), 0);
      check($sformatf("vec%0d_idle_strobes", v), int'({cs_n, rd_n, wr_n, ad_n}), 15);
    end

    // reset in the middle of a write data phase, with a read queued
    @(negedge clk);
    req_conf = 1'b1;
    @(negedge clk);
    req_conf = 1'b0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!cs_n && ad_n) begin
        found = 1;
        break;
      end
    end
    check("abort_reach_data", found, 1);
    req_lect = 1'b1;
    @(negedge clk);
    req_lect = 1'b0;
    #1 clr = 1'b1;
    #2 clr = 1'b0;
    @(negedge clk);
    check("abort_strobes", int'({cs_n, rd_n, wr_n, ad_n}), 15);
    check("abort_busy", int'(busy), 0);
    late_busy = 0; late_done = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (busy) late_busy++;
      if (done) late_done++;
    end
    check("abort_no_done", late_done, 0);
    check("abort_pend_cleared", late_busy, 0);

    // config and read requested together: config first, read right after
    @(negedge clk);
    din = 8'h37; exp_din = 8'h37;
    req_conf = 1'b1; req_lect = 1'b1;
    observe(400, 0);
    check_seq("pri_conf", 3, 3, 0, 1, 5'b01100, 1'b0, 1'b0);
    observe(400, 0);
    check_seq("pri_lect", 10, 1, 9, 0, 5'b10011, 1'b0, 1'b1);

    // init requested while a read runs: no preemption, init follows at once
    @(negedge clk);
    din = 8'h5A; exp_din = 8'h5A;
    req_lect = 1'b1;
    observe(400, 30);
    check_seq("queue_lect", 10, 1, 9, 0, 5'b10011, 1'b0, 1'b1);
    observe(400, 0);
    check_seq("queue_ini", 14, 14, 0, 0, 5'b01100, 1'b1, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
